id_ex_pipe_reg: RTL and testbench

- ID/EX pipeline register of the 5-stage MIPS datapath.
- Captures decoded fields, register-file read data and main-control bits from the ID stage each cycle.
- Presents them to the EX stage, where Op_out/funct_out feed the ALU control stage.
- Supports stall (hold), flush (bubble insertion), a valid bit and load-use hazard detection against the instruction in ID.

---
 rtl/id_ex_pipe_reg.sv | 134 +++++++++++++
 tb/tb_id_ex_pipe_reg.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/id_ex_pipe_reg.sv
// ID/EX pipeline register with stall/flush, valid bit and load-use hazard detection.
// Optional bubble counter enabled by defining ID_EX_BUBBLE_CNT_EN.
module id_ex_pipe_reg #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  Stall,
  input  logic                  Flush,
  input  logic                  Valid_in,
  input  logic [5:0]            Op_in,
  input  logic [5:0]            funct_in,
  input  logic [REG_ADDR_W-1:0] Rs_in,
  input  logic [REG_ADDR_W-1:0] Rt_in,
  input  logic [REG_ADDR_W-1:0] Rd_in,
  input  logic [4:0]            shamt_in,
  input  logic [DATA_W-1:0]     Imm_in,
  input  logic [DATA_W-1:0]     ReadData1_in,
  input  logic [DATA_W-1:0]     ReadData2_in,
  input  logic [DATA_W-1:0]     PCPlus4_in,
  input  logic [5:0]            Ctrl_in,
  output logic                  Valid_out,
  output logic [5:0]            Op_out,
  output logic [5:0]            funct_out,
  output logic [REG_ADDR_W-1:0] Rs_out,
  output logic [REG_ADDR_W-1:0] Rt_out,
  output logic [REG_ADDR_W-1:0] Rd_out,
  output logic [4:0]            shamt_out,
  output logic [DATA_W-1:0]     Imm_out,
  output logic [DATA_W-1:0]     ReadData1_out,
  output logic [DATA_W-1:0]     ReadData2_out,
  output logic [DATA_W-1:0]     PCPlus4_out,
  output logic [5:0]            Ctrl_out,
`ifdef ID_EX_BUBBLE_CNT_EN
  output logic [CNT_W-1:0]      BubbleCount,
`endif
  output logic                  LoadUseHazard
);

  typedef struct packed {
    logic                  valid;
    logic [5:0]            op;
    logic [5:0]            funct;
    logic [REG_ADDR_W-1:0] rs;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic [4:0]            shamt;
    logic [DATA_W-1:0]     imm;
    logic [DATA_W-1:0]     rd1;
    logic [DATA_W-1:0]     rd2;
    logic [DATA_W-1:0]     pc4;
    logic [5:0]            ctrl;
  } stage_t;

  stage_t stage_in_s;
  stage_t stage_d;
  stage_t stage_q;

  assign stage_in_s = {Valid_in, Op_in, funct_in, Rs_in, Rt_in, Rd_in, shamt_in,
                       Imm_in, ReadData1_in, ReadData2_in, PCPlus4_in, Ctrl_in};

  // Next contents: all-zero bubble on flush, hold on stall, else load with control masked when invalid
  always_comb begin
    stage_d = stage_q;
    if (Flush) begin
      stage_d = '0;
    end else if (Stall) begin
      stage_d = stage_q;
    end else begin
      stage_d = stage_in_s;
      if (Valid_in) begin
        stage_d.ctrl = Ctrl_in;
      end else begin
        stage_d.ctrl = 6'd0;
      end
    end
  end

  // Pipeline register with synchronous reset
  always_ff @(posedge Clk) begin
    if (Reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  assign Valid_out     = stage_q.valid;
  assign Op_out        = stage_q.op;
  assign funct_out     = stage_q.funct;
  assign Rs_out        = stage_q.rs;
  assign Rt_out        = stage_q.rt;
  assign Rd_out        = stage_q.rd;
  assign shamt_out     = stage_q.shamt;
  assign Imm_out       = stage_q.imm;
  assign ReadData1_out = stage_q.rd1;
  assign ReadData2_out = stage_q.rd2;
  assign PCPlus4_out   = stage_q.pc4;
  assign Ctrl_out      = stage_q.ctrl;

  // A load writing $0 never creates a real dependency, so rt==0 is excluded
  assign LoadUseHazard = stage_q.valid & stage_q.ctrl[1] &
                         (stage_q.rt != {REG_ADDR_W{1'b0}}) &
                         ((stage_q.rt == Rs_in) | (stage_q.rt == Rt_in));

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_W-1:0] bubble_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q;

  // Saturating count of inserted bubbles
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (Flush && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      bubble_cnt_d = bubble_cnt_q;
    end
  end

  // Bubble counter register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      bubble_cnt_q <= {CNT_W{1'b0}};
    end else begin
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign BubbleCount = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Table-driven bench for id_ex_pipe_reg; bubble-count checks apply when ID_EX_BUBBLE_CNT_EN is defined.
module tb_id_ex_pipe_reg;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 2;

  typedef struct packed {
    logic          valid;
    logic [5:0]    op;
    logic [5:0]    funct;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic [AW-1:0] rd;
    logic [4:0]    shamt;
    logic [DW-1:0] imm;
    logic [DW-1:0] rd1;
    logic [DW-1:0] rd2;
    logic [DW-1:0] pc4;
    logic [5:0]    ctrl;
  } fields_t;

  typedef struct {
    logic    rst;
    logic    stall;
    logic    flush;
    fields_t in;
    fields_t exp;
    logic    haz;
    int      cnt;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset, Stall, Flush;
  fields_t in_s;
  fields_t act_s;
  logic Valid_out, LoadUseHazard;
  logic [5:0] Op_out, funct_out, Ctrl_out;
  logic [AW-1:0] Rs_out, Rt_out, Rd_out;
  logic [4:0] shamt_out;
  logic [DW-1:0] Imm_out, ReadData1_out, ReadData2_out, PCPlus4_out;
  logic [CW-1:0] BubbleCount;

  int n_checks = 0;
  int n_fail = 0;

  always #5 Clk = ~Clk;

  id_ex_pipe_reg #(.DATA_W(DW), .REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .Clk(Clk), .Reset(Reset), .Stall(Stall), .Flush(Flush),
    .Valid_in(in_s.valid), .Op_in(in_s.op), .funct_in(in_s.funct),
    .Rs_in(in_s.rs), .Rt_in(in_s.rt), .Rd_in(in_s.rd), .shamt_in(in_s.shamt),
    .Imm_in(in_s.imm), .ReadData1_in(in_s.rd1), .ReadData2_in(in_s.rd2),
    .PCPlus4_in(in_s.pc4), .Ctrl_in(in_s.ctrl),
    .Valid_out(Valid_out), .Op_out(Op_out), .funct_out(funct_out),
    .Rs_out(Rs_out), .Rt_out(Rt_out), .Rd_out(Rd_out), .shamt_out(shamt_out),
    .Imm_out(Imm_out), .ReadData1_out(ReadData1_out), .ReadData2_out(ReadData2_out),
    .PCPlus4_out(PCPlus4_out), .Ctrl_out(Ctrl_out),
`ifdef ID_EX_BUBBLE_CNT_EN
    .BubbleCount(BubbleCount),
`endif
    .LoadUseHazard(LoadUseHazard)
  );

`ifndef ID_EX_BUBBLE_CNT_EN
  assign BubbleCount = '0;
`endif

  assign act_s = {Valid_out, Op_out, funct_out, Rs_out, Rt_out, Rd_out, shamt_out,
                  Imm_out, ReadData1_out, ReadData2_out, PCPlus4_out, Ctrl_out};

  function automatic fields_t mk(input logic v, input logic [5:0] op, input logic [5:0] fn,
                                 input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                                 input logic [AW-1:0] rd, input logic [4:0] sh,
                                 input logic [DW-1:0] imm, input logic [DW-1:0] d1,
                                 input logic [DW-1:0] d2, input logic [DW-1:0] pc,
                                 input logic [5:0] ctrl);
    fields_t f;
    f = {v, op, fn, rs, rt, rd, sh, imm, d1, d2, pc, ctrl};
    return f;
  endfunction

  function automatic vec_t mkv(input logic r, input logic s, input logic f,
                               input fields_t i, input fields_t e, input logic h, input int c);
    vec_t v;
    v.rst = r; v.stall = s; v.flush = f; v.in = i; v.exp = e; v.haz = h; v.cnt = c;
    return v;
  endfunction

  task automatic check(input string name, input fields_t exp, input logic exp_haz, input int exp_cnt);
    n_checks++;
    if (act_s !== exp) begin
      n_fail++;
      $display("FAIL %s: outputs got %h expected %h", name, act_s, exp);
    end
    n_checks++;
    if (LoadUseHazard !== exp_haz) begin
      n_fail++;
      $display("FAIL %s hazard: got %b expected %b", name, LoadUseHazard, exp_haz);
    end
`ifdef ID_EX_BUBBLE_CNT_EN
    n_checks++;
    if (BubbleCount !== CW'(exp_cnt)) begin
      n_fail++;
      $display("FAIL %s bubble count: got %0d expected %0d", name, BubbleCount, exp_cnt);
    end
`endif
  endtask

  vec_t vecs[17];

  initial begin
    fields_t z, a, add_i, other1, other2, sub_i, lw_i, use_i, nouse_i, lw0_i, inv_i, inv_e, lwinv_e;
    z       = '0;
    a       = mk(1'b1, 6'h3f, 6'h3f, 5'd31, 5'd31, 5'd31, 5'd31, 32'hffffffff, 32'hffffffff, 32'hffffffff, 32'hffffffff, 6'h3f);
    add_i   = mk(1'b1, 6'h00, 6'h20, 5'd8, 5'd9, 5'd10, 5'd0, 32'd0, 32'd5, 32'd7, 32'h104, 6'h21);
    other1  = mk(1'b1, 6'h23, 6'h00, 5'd1, 5'd2, 5'd3, 5'd4, 32'h55, 32'h66, 32'h77, 32'h88, 6'h1b);
    other2  = mk(1'b0, 6'h2b, 6'h11, 5'd4, 5'd5, 5'd6, 5'd7, 32'h99, 32'haa, 32'hbb, 32'hcc, 6'h14);
    sub_i   = mk(1'b1, 6'h00, 6'h22, 5'd11, 5'd12, 5'd13, 5'd0, 32'd0, 32'd3, 32'd4, 32'h108, 6'h21);
    lw_i    = mk(1'b1, 6'h23, 6'h00, 5'd8, 5'd9, 5'd0, 5'd0, 32'd4, 32'd100, 32'd0, 32'h10c, 6'h1b);
    use_i   = mk(1'b1, 6'h00, 6'h20, 5'd9, 5'd10, 5'd11, 5'd0, 32'd0, 32'd1, 32'd2, 32'h110, 6'h21);
    nouse_i = mk(1'b1, 6'h00, 6'h20, 5'd5, 5'd6, 5'd7, 5'd0, 32'd0, 32'd1, 32'd2, 32'h110, 6'h21);
    lw0_i   = mk(1'b1, 6'h23, 6'h00, 5'd0, 5'd0, 5'd0, 5'd0, 32'd8, 32'd0, 32'd0, 32'h114, 6'h1b);
    inv_i   = mk(1'b0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd4, 32'd5, 32'd6, 32'd7, 32'd8, 6'h21);
    inv_e   = mk(1'b0, 6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 5'd4, 32'd5, 32'd6, 32'd7, 32'd8, 6'h00);
    lwinv_e = mk(1'b0, 6'h23, 6'h00, 5'd8, 5'd9, 5'd0, 5'd0, 32'd4, 32'd100, 32'd0, 32'h10c, 6'h00);
    lw_i.valid = 1'b1;

    vecs[0]  = mkv(1'b1, 1'b1, 1'b1, a,       z,     1'b0, 0);
    vecs[1]  = mkv(1'b1, 1'b1, 1'b1, a,       z,     1'b0, 0);
    vecs[2]  = mkv(1'b0, 1'b0, 1'b0, add_i,   add_i, 1'b0, 0);
    vecs[3]  = mkv(1'b0, 1'b1, 1'b0, other1,  add_i, 1'b0, 0);
    vecs[4]  = mkv(1'b0, 1'b1, 1'b0, other2,  add_i, 1'b0, 0);
    vecs[5]  = mkv(1'b0, 1'b1, 1'b0, a,       add_i, 1'b0, 0);
    vecs[6]  = mkv(1'b0, 1'b0, 1'b0, sub_i,   sub_i, 1'b0, 0);
    vecs[7]  = mkv(1'b0, 1'b0, 1'b0, lw_i,    lw_i,  1'b1, 0);
    vecs[8]  = mkv(1'b0, 1'b1, 1'b0, use_i,   lw_i,  1'b1, 0);
    vecs[9]  = mkv(1'b0, 1'b1, 1'b0, nouse_i, lw_i,  1'b0, 0);
    vecs[10] = mkv(1'b0, 1'b0, 1'b0, lw0_i,   lw0_i, 1'b0, 0);
    vecs[11] = mkv(1'b0, 1'b1, 1'b1, add_i,   z,     1'b0, 1);
    vecs[12] = mkv(1'b0, 1'b0, 1'b0, inv_i,   inv_e, 1'b0, 1);
    vecs[13] = mkv(1'b0, 1'b0, 1'b1, a,       z,     1'b0, 2);
    vecs[14] = mkv(1'b0, 1'b0, 1'b0, add_i,   add_i, 1'b0, 2);
    vecs[15] = mkv(1'b1, 1'b1, 1'b1, a,       z,     1'b0, 0);
    vecs[16] = mkv(1'b0, 1'b0, 1'b0, {1'b0, lw_i[$bits(fields_t)-2:0]}, lwinv_e, 1'b0, 0);

    Reset = 1'b1; Stall = 1'b0; Flush = 1'b0; in_s = a;
    #1;
    for (int i = 0; i < 17; i++) begin
      Reset = vecs[i].rst; Stall = vecs[i].stall; Flush = vecs[i].flush; in_s = vecs[i].in;
      @(posedge Clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp, vecs[i].haz, vecs[i].cnt);
    end

    // Back-to-back flushes: bubble each cycle, counter saturates at 3 for a 2-bit counter
    for (int k = 0; k < 5; k++) begin
      Reset = 1'b0; Stall = 1'b0; Flush = 1'b1; in_s = lw_i;
      @(posedge Clk);
      #1;
      check($sformatf("flush_seq%0d", k), z, 1'b0, (k < 3) ? k + 1 : 3);
    end

    // Recovery load after the flush run keeps the saturated count
    Flush = 1'b0; in_s = lw_i;
    @(posedge Clk);
    #1;
    check("recover_load", lw_i, 1'b1, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
